axi_loader_sequencer: RTL and testbench
=======================================

Name: axi_loader_sequencer

Overview:
Upstream stimulus stage for one AXI master loader. Generates a programmed number of pseudo-random read/write requests (ID, AxLEN, direction) and pushes them into the loader's request FIFO in batches no larger than the FIFO depth. For each batch it pulses the loader start and waits for the loader to go idle. It reports done/busy and a performance cycle count to the testbench or PMU layer.

Parameters:
FIFO_DEPTH, 32, depth of the downstream loader FIFO; maximum pushes per batch
ID_W_WIDTH, 5, write ID width
ID_R_WIDTH, 5, read ID width
MAX_ID_WIDTH, max(ID_W_WIDTH,ID_R_WIDTH), width of id_o
CNT_WIDTH, 16, width of the request-count config and status counters

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
cfg_valid_i  in  1  one-cycle pulse that latches config and starts a run; ignored unless in IDLE
num_req_i  in  CNT_WIDTH  total requests in the run; 0 means finish immediately
mode_i  in  2  0 = all reads, 1 = all writes, 2/3 = mixed (LFSR bit 7 set means write)
seed_i  in  16  LFSR seed; 0 is replaced by 16'h0001
axlen_mask_i  in  8  AND-mask applied to the random AxLEN
req_depth_cfg_i  in  8  value forwarded to the loader's req_depth
id_o  out  MAX_ID_WIDTH  request ID to loader FIFO
write_o  out  1  request direction
axlen_o  out  8  request burst length
fifo_push_o  out  1  push strobe into loader FIFO
req_depth_o  out  8  registered copy of req_depth_cfg_i
start_o  out  1  start request to loader
idle_i  in  1  loader idle indication
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at run completion
req_sent_o  out  CNT_WIDTH  requests pushed so far in this run
cycles_o  out  32  performance cycle count (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; LFSR = 16'h0001; counters 0.
- LFSR: 16-bit Galois, taps 0xB400, advances once per push. Fields:
  - id_o = lfsr[MAX_ID_WIDTH-1:0]
  - axlen_o = lfsr[15:8] & axlen_mask
  - write_o from mode: 0 gives 0, 1 gives 1, 2/3 gives lfsr[7].
- All request outputs are registered. fifo_push_o is high for exactly one cycle per request, with id/write/axlen valid in that same cycle.
- States:
  - IDLE: on cfg_valid_i, latch all config, load the seed, clear req_sent_o and remaining = num_req_i. Go to FILL, or to DONE if num_req_i == 0.
  - FILL: push one request per cycle. batch = min(remaining, FIFO_DEPTH). After the last push of the batch go to GAP.
  - GAP: one idle cycle so the loader FIFO shows valid data. Then go to START.
  - START: assert start_o and hold it until idle_i == 0, then go to WAIT.
    - If idle_i stays 1 for 1024 cycles, go to DONE anyway; this is an error-tolerant exit.
  - WAIT: start_o = 0; wait for idle_i == 1. Then go to FILL if remaining > 0, else DONE.
  - DONE: done_o = 1 for one cycle, then IDLE.
- busy_o = 1 in every state except IDLE.
- cfg_valid_i while busy is ignored; config is not re-latched.
- req_sent_o saturates at num_req_i and never wraps.
- Pushes never exceed FIFO_DEPTH between consecutive start pulses. The loader FIFO provides no ready signal, so this limit is the only overflow guard.
- Reset mid-run: all state returns to reset values immediately. Any partially filled loader FIFO is the loader reset's responsibility.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: cycles_o counts clock cycles from IDLE→FILL through the DONE cycle inclusive. It is cleared on each cfg_valid_i accepted in IDLE, holds its value afterwards, and saturates at 32'hFFFFFFFF.
- Undefined: cycles_o tied to 0 and no counter logic is built.

Decomposition:
- Package axi_seq_pkg holds:
  - the state enum (IDLE, FILL, GAP, START, WAIT, DONE)
  - mode encodings (SEQ_MODE_RD = 0, SEQ_MODE_WR = 1, SEQ_MODE_MIX = 2)
  - LFSR_TAPS = 16'hB400, LFSR_DEFAULT_SEED = 16'h0001, START_TIMEOUT = 1024
- Sub-module seq_lfsr16: a 16-bit Galois LFSR with load/seed/advance inputs. It is instantiated once.

Test Plan:
- Reset with no activity → all outputs 0, busy_o = 0; cfg_valid_i pulse with num_req_i = 0 → done_o pulses within 2 cycles, no fifo_push_o.
- num_req_i = 5, mode_i = 1, axlen_mask_i = 8'h03, FIFO_DEPTH = 32 → 5 consecutive pushes, all write_o = 1 and axlen_o ≤ 3, then one start_o. Model loader idle drop/return → done_o, req_sent_o = 5.
- num_req_i = 70, FIFO_DEPTH = 32 → batches of 32, 32 and 6, with exactly 3 start_o assertions. No batch pushes while idle_i == 0.
- seed_i = 0 versus seed_i = 1, mode_i = 2 → identical id/axlen/write sequences; the write_o mix matches the golden LFSR model.
- idle_i held at 1 after start_o → exit after 1024 cycles with done_o; cfg_valid_i during a run is ignored (req_sent_o unaffected).
- With SEQ_PERF_CNT_EN, 3 requests and a 10-cycle loader busy period → cycles_o equals the exact FILL-to-DONE cycle count. Async reset asserted in FILL → outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/axi_seq_pkg.sv
// Shared types and constants for the AXI loader request sequencer.
package axi_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      GAP,
      START,
      WAIT,
      DONE
   } seq_state_e;

   localparam logic [1:0]  SEQ_MODE_RD       = 2'd0;
   localparam logic [1:0]  SEQ_MODE_WR       = 2'd1;
   localparam logic [1:0]  SEQ_MODE_MIX      = 2'd2;

   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'h0001;
   localparam int          START_TIMEOUT     = 1024;

   // Right-shifting Galois step: the bit shifted out folds back through the taps.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/axi_loader_sequencer_if.sv
// Request/start/idle bundle between the sequencer (master) and the AXI loader (slave).
interface axi_loader_sequencer_if #(
   parameter int ID_WIDTH = 5
);
   logic [ID_WIDTH-1:0] id;
   logic                write;
   logic [7:0]          axlen;
   logic                fifo_push;
   logic [7:0]          req_depth;
   logic                start;
   logic                idle;

   modport master (output id, write, axlen, fifo_push, req_depth, start, input idle);
   modport slave  (input id, write, axlen, fifo_push, req_depth, start, output idle);
endinterface

// File: rtl/seq_lfsr16.sv
// 16-bit Galois LFSR; a zero seed is replaced by the default so the register never locks up.
module seq_lfsr16
   import axi_seq_pkg::*;
(
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] state
);

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state <= LFSR_DEFAULT_SEED;
      end else if (load) begin
         state <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
      end else if (advance) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/axi_loader_sequencer.sv
// Batches pseudo-random AXI requests into the loader FIFO and kicks the loader per batch.
// Optional cycle counter on cycles_o is built only when SEQ_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for cfg_valid_i
// FILL  | one push per cycle until the batch is in the FIFO
// GAP   | one quiet cycle so the last push settles in the FIFO
// START | start held until the loader leaves idle, or timeout
// WAIT  | loader busy; refill or finish when it returns to idle
// DONE  | one-cycle done pulse
module axi_loader_sequencer
   import axi_seq_pkg::*;
#(
   parameter int FIFO_DEPTH   = 32,
   parameter int ID_W_WIDTH   = 5,
   parameter int ID_R_WIDTH   = 5,
   parameter int MAX_ID_WIDTH = (ID_W_WIDTH > ID_R_WIDTH) ? ID_W_WIDTH : ID_R_WIDTH,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk_i,
   input  logic                  arstn_i,
   input  logic                  cfg_valid_i,
   input  logic [CNT_WIDTH-1:0]  num_req_i,
   input  logic [1:0]            mode_i,
   input  logic [15:0]           seed_i,
   input  logic [7:0]            axlen_mask_i,
   input  logic [7:0]            req_depth_cfg_i,
   axi_loader_sequencer_if.master ldr,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [CNT_WIDTH-1:0]  req_sent_o,
   output logic [31:0]           cycles_o
);

   localparam int BATCH_W = $clog2(FIFO_DEPTH + 1);
   localparam int TMR_W   = $clog2(START_TIMEOUT);

   seq_state_e               state;
   logic [1:0]               mode_q;
   logic [7:0]               mask_q;
   logic [CNT_WIDTH-1:0]     num_req_q;
   logic [CNT_WIDTH-1:0]     remaining;
   logic [BATCH_W-1:0]       batch_left;
   logic [TMR_W-1:0]         start_tmr;
   logic [15:0]              lfsr;
   logic [MAX_ID_WIDTH-1:0]  id_q;
   logic                     write_q;
   logic [7:0]               axlen_q;
   logic                     push_q;
   logic                     start_q;
   logic [7:0]               req_depth_q;
   logic [CNT_WIDTH-1:0]     batch_src;
   logic [BATCH_W-1:0]       batch_init;
   logic                     write_next;
   logic                     cfg_accept;
   logic                     unused_lfsr_bits;

   assign cfg_accept       = (state == IDLE) && cfg_valid_i;
   assign unused_lfsr_bits = ^lfsr;

   seq_lfsr16 u_lfsr (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .load    (cfg_accept),
      .seed    (seed_i),
      .advance (state == FILL),
      .state   (lfsr)
   );

   // Batch size is taken from the raw config when starting, from the residue when refilling.
   always_comb begin
      batch_src  = (state == IDLE) ? num_req_i : remaining;
      batch_init = (batch_src > CNT_WIDTH'(FIFO_DEPTH)) ? BATCH_W'(FIFO_DEPTH)
                                                         : batch_src[BATCH_W-1:0];
      case (mode_q)
         SEQ_MODE_RD: write_next = 1'b0;
         SEQ_MODE_WR: write_next = 1'b1;
         default:     write_next = lfsr[7];
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state       <= IDLE;
         mode_q      <= '0;
         mask_q      <= '0;
         num_req_q   <= '0;
         remaining   <= '0;
         batch_left  <= '0;
         start_tmr   <= '0;
         id_q        <= '0;
         write_q     <= 1'b0;
         axlen_q     <= '0;
         push_q      <= 1'b0;
         start_q     <= 1'b0;
         done_o      <= 1'b0;
         req_sent_o  <= '0;
         req_depth_q <= '0;
      end else begin
         push_q      <= 1'b0;
         done_o      <= 1'b0;
         req_depth_q <= req_depth_cfg_i;
         case (state)
            IDLE: begin
               if (cfg_valid_i) begin
                  mode_q     <= mode_i;
                  mask_q     <= axlen_mask_i;
                  num_req_q  <= num_req_i;
                  remaining  <= num_req_i;
                  req_sent_o <= '0;
                  batch_left <= batch_init;
                  if (num_req_i == '0) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            FILL: begin
               push_q     <= 1'b1;
               id_q       <= lfsr[MAX_ID_WIDTH-1:0];
               axlen_q    <= lfsr[15:8] & mask_q;
               write_q    <= write_next;
               remaining  <= remaining - 1'b1;
               batch_left <= batch_left - 1'b1;
               if (req_sent_o != num_req_q) req_sent_o <= req_sent_o + 1'b1;
               if (batch_left == BATCH_W'(1)) state <= GAP;
            end
            GAP: begin
               state     <= START;
               start_q   <= 1'b1;
               start_tmr <= TMR_W'(START_TIMEOUT - 1);
            end
            START: begin
               if (!ldr.idle) begin
                  state   <= WAIT;
                  start_q <= 1'b0;
               end else if (start_tmr == '0) begin
                  // Loader never responded: give up rather than hang the run.
                  state   <= DONE;
                  start_q <= 1'b0;
                  done_o  <= 1'b1;
               end else begin
                  start_tmr <= start_tmr - 1'b1;
               end
            end
            WAIT: begin
               if (ldr.idle) begin
                  if (remaining != '0) begin
                     state      <= FILL;
                     batch_left <= batch_init;
                  end else begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o        = (state != IDLE);
   assign ldr.id        = id_q;
   assign ldr.write     = write_q;
   assign ldr.axlen     = axlen_q;
   assign ldr.fifo_push = push_q;
   assign ldr.start     = start_q;
   assign ldr.req_depth = req_depth_q;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycles_q;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         cycles_q <= '0;
      end else if (cfg_accept) begin
         cycles_q <= '0;
      end else if (state != IDLE && cycles_q != 32'hFFFF_FFFF) begin
         cycles_q <= cycles_q + 1'b1;
      end
   end

   assign cycles_o = cycles_q;
`else
   assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_axi_loader_sequencer.sv
// Scoreboard bench for axi_loader_sequencer with a behavioural loader and request model.
module tb_axi_loader_sequencer;

   localparam int DEPTH = 32;
   localparam int IDW   = 5;
   localparam int CW    = 16;

   logic          clk_i = 1'b0;
   logic          arstn_i = 1'b0;
   logic          cfg_valid_i = 1'b0;
   logic [CW-1:0] num_req_i = '0;
   logic [1:0]    mode_i = '0;
   logic [15:0]   seed_i = '0;
   logic [7:0]    axlen_mask_i = '0;
   logic [7:0]    req_depth_cfg_i = '0;
   logic          busy_o, done_o;
   logic [CW-1:0] req_sent_o;
   logic [31:0]   cycles_o;

   always #5 clk_i = ~clk_i;

   axi_loader_sequencer_if #(.ID_WIDTH(IDW)) ldr_bus ();

   axi_loader_sequencer #(
      .FIFO_DEPTH(DEPTH), .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDW), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk_i), .arstn_i(arstn_i), .cfg_valid_i(cfg_valid_i),
      .num_req_i(num_req_i), .mode_i(mode_i), .seed_i(seed_i),
      .axlen_mask_i(axlen_mask_i), .req_depth_cfg_i(req_depth_cfg_i),
      .ldr(ldr_bus.master), .busy_o(busy_o), .done_o(done_o),
      .req_sent_o(req_sent_o), .cycles_o(cycles_o)
   );

   typedef struct packed {
      logic [IDW-1:0] id;
      logic           wr;
      logic [7:0]     axlen;
   } req_t;

   req_t exp_q[$];
   int   exp_batch_q[$];
   int   exp_sent_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   run_pushes = 0, batch_pushes = 0, starts = 0, dones = 0;
   int   start_len = 0, last_start_len = 0;
   logic start_d = 1'b0;

   bit   loader_dead = 1'b0, loader_rand = 1'b0;
   int   drop_dly = 0, busy_len = 10;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: event occurred, expected none", name);
   endtask

   function automatic logic [15:0] galois(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // Reference: the whole request stream and batch split are computed up front.
   function automatic int expect_run(input int n, input logic [1:0] mode, input logic [15:0] seed,
                                     input logic [7:0] mask, input bit dead);
      logic [15:0] s;
      int total, rem, nb;
      req_t r;
      s     = (seed == 16'h0) ? 16'h1 : seed;
      total = (dead && n > DEPTH) ? DEPTH : n;
      for (int i = 0; i < total; i++) begin
         r.id    = s[IDW-1:0];
         r.wr    = (mode == 2'd0) ? 1'b0 : (mode == 2'd1) ? 1'b1 : s[7];
         r.axlen = s[15:8] & mask;
         exp_q.push_back(r);
         s = galois(s);
      end
      rem = total;
      nb  = 0;
      while (rem > 0) begin
         exp_batch_q.push_back(rem > DEPTH ? DEPTH : rem);
         rem -= (rem > DEPTH ? DEPTH : rem);
         nb++;
      end
      exp_sent_q.push_back(total);
      return nb;
   endfunction

   // Loader model: leaves idle some cycles after seeing start, stays busy, then returns.
   initial begin
      ldr_bus.idle = 1'b1;
      forever begin
         @(negedge clk_i);
         if (ldr_bus.start && ldr_bus.idle && !loader_dead) begin
            if (loader_rand) begin
               drop_dly = $urandom_range(0, 3);
               busy_len = $urandom_range(1, 8);
            end
            repeat (drop_dly) @(negedge clk_i);
            ldr_bus.idle = 1'b0;
            repeat (busy_len) @(negedge clk_i);
            ldr_bus.idle = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a push, start or done.
   always @(negedge clk_i) begin
      req_t r;
      int   eb;
      if (!arstn_i) begin
         batch_pushes = 0;
         start_d      = 1'b0;
         start_len    = 0;
      end else begin
         if (ldr_bus.fifo_push) begin
            run_pushes++;
            batch_pushes++;
            check("push_while_loader_busy", ldr_bus.idle, 1);
            check("req_sent_tracks_pushes", req_sent_o, run_pushes);
            if (exp_q.size() == 0) begin
               fail_now("unexpected_push");
            end else begin
               r = exp_q.pop_front();
               check("req_id", ldr_bus.id, r.id);
               check("req_write", ldr_bus.write, r.wr);
               check("req_axlen", ldr_bus.axlen, r.axlen);
            end
         end
         if (ldr_bus.start) start_len++;
         if (ldr_bus.start && !start_d) begin
            starts++;
            if (exp_batch_q.size() == 0) begin
               fail_now("unexpected_start");
            end else begin
               eb = exp_batch_q.pop_front();
               check("batch_size", batch_pushes, eb);
            end
            batch_pushes = 0;
         end
         if (!ldr_bus.start && start_d) begin
            last_start_len = start_len;
            start_len      = 0;
         end
         start_d = ldr_bus.start;
         if (done_o) begin
            dones++;
            if (exp_sent_q.size() == 0) fail_now("unexpected_done");
            else check("req_sent_at_done", req_sent_o, exp_sent_q.pop_front());
         end
      end
   end

   task automatic run(input int n, input logic [1:0] mode, input logic [15:0] seed,
                      input logic [7:0] mask, input bit dead, input bit poke, input int budget);
      int nb, target, s0, waited;
      logic [7:0] dcfg;
      nb          = expect_run(n, mode, seed, mask, dead);
      loader_dead = dead;
      target      = dones + 1;
      s0          = starts;
      dcfg        = 8'($urandom);
      @(negedge clk_i);
      num_req_i       = CW'(n);
      mode_i          = mode;
      seed_i          = seed;
      axlen_mask_i    = mask;
      req_depth_cfg_i = dcfg;
      run_pushes      = 0;
      cfg_valid_i     = 1'b1;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      #1;
      waited = 0;
      while (dones < target && waited < budget) begin
         // A config pulse mid-run must not be latched or restart anything.
         cfg_valid_i = poke && (waited == 100);
         if (poke && waited == 100) begin
            num_req_i = CW'(99);
            mode_i    = 2'd0;
         end
         @(negedge clk_i);
         #1;
         waited++;
      end
      cfg_valid_i = 1'b0;
      if (dones < target) begin
         fail_now("done_timeout");
      end else begin
         check("pushes_outstanding", exp_q.size(), 0);
         check("batches_outstanding", exp_batch_q.size(), 0);
         check("start_count", starts - s0, nb);
         check("req_depth_copy", ldr_bus.req_depth, dcfg);
         @(negedge clk_i);
         #1;
         check("busy_after_done", busy_o, 0);
         check("done_one_cycle", done_o, 0);
      end
      exp_q.delete();
      exp_batch_q.delete();
      exp_sent_q.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_push", ldr_bus.fifo_push, 0);
      check("rst_start", ldr_bus.start, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_req_sent", req_sent_o, 0);
      check("rst_cycles", cycles_o, 0);
      check("rst_id", ldr_bus.id, 0);
      check("rst_axlen", ldr_bus.axlen, 0);
      arstn_i = 1'b1;
      repeat (2) @(negedge clk_i);

      loader_rand = 1'b0;
      drop_dly    = 0;
      busy_len    = 10;
      run(0, 2'd2, 16'h1234, 8'hFF, 1'b0, 1'b0, 2);
      run(5, 2'd1, 16'hACE1, 8'h03, 1'b0, 1'b0, 200);
      run(70, 2'd3, 16'h5A5A, 8'hFF, 1'b0, 1'b0, 400);
      run(20, 2'd2, 16'h0000, 8'hFF, 1'b0, 1'b0, 200);
      run(20, 2'd2, 16'h0001, 8'hFF, 1'b0, 1'b0, 200);

      run(3, 2'd0, 16'hBEEF, 8'h0F, 1'b0, 1'b0, 200);
`ifdef SEQ_PERF_CNT_EN
      check("perf_cycles", cycles_o, 3 + 1 * (2 + 10) + 1);
`else
      check("perf_cycles_off", cycles_o, 0);
`endif

      loader_rand = 1'b1;
      for (int i = 0; i < 6; i++)
         run($urandom_range(1, 80), 2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom),
             1'b0, 1'b0, 2000);
      loader_rand = 1'b0;

      run(5, 2'd2, 16'h7777, 8'hFF, 1'b1, 1'b1, 1200);
      check("timeout_start_cycles", last_start_len, 1024);
      loader_dead = 1'b0;

      void'(expect_run(70, 2'd2, 16'h4321, 8'hFF, 1'b0));
      @(negedge clk_i);
      num_req_i   = CW'(70);
      mode_i      = 2'd2;
      seed_i      = 16'h4321;
      run_pushes  = 0;
      cfg_valid_i = 1'b1;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      repeat (8) @(negedge clk_i);
      #1;
      check("mid_fill_pushing", ldr_bus.fifo_push, 1);
      #2 arstn_i = 1'b0;
      #1;
      check("arst_push", ldr_bus.fifo_push, 0);
      check("arst_busy", busy_o, 0);
      check("arst_req_sent", req_sent_o, 0);
      check("arst_start", ldr_bus.start, 0);
      check("arst_axlen", ldr_bus.axlen, 0);
      exp_q.delete();
      exp_batch_q.delete();
      exp_sent_q.delete();
      @(negedge clk_i);
      arstn_i = 1'b1;
      repeat (5) @(negedge clk_i);
      #1;
      check("post_arst_idle", busy_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
